// File: rtl/sync_sched_pkg.sv
// sync_sched_pkg: shared state type and one-hot helper for the channel scheduler
package sync_sched_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam int MAX_CH = 16;

    function automatic logic [MAX_CH-1:0] onehot(input int idx, input int ch);
        return (idx >= 0 && idx < ch) ? (MAX_CH'(1) << idx) : '0;
    endfunction

endpackage

// File: rtl/sync_channel_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting just after ptr, wrapping
module rr_arbiter #(
    parameter int CH = 4,
    parameter int CW = 2
) (
    input  logic [CH-1:0] eligible,
    input  logic [CW-1:0] ptr,
    output logic [CW-1:0] win_idx,
    output logic          win_valid
);

    int w_best;
    int w_dist;

    // Winner is the eligible channel with the smallest circular distance past ptr
    always_comb begin
        win_idx = '0;
        w_best  = CH;
        w_dist  = 0;
        for (int j = 0; j < CH; j++) begin
            w_dist = (j + 2 * CH - int'(ptr) - 1) % CH;
            if (eligible[j] && w_dist < w_best) begin
                w_best  = w_dist;
                win_idx = CW'(j);
            end
        end
    end

    assign win_valid = |eligible;

endmodule

// File: rtl/sync_channel_scheduler.sv
// sync_channel_scheduler: round-robin sharing of one fast-to-slow synchronizer path
module sync_channel_scheduler
    import sync_sched_pkg::*;
#(
    parameter int N    = 12,
    parameter int CH   = 4,
    parameter int HOLD = 8,
    localparam int CW  = ($clog2(CH) > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH-1:0]   req,
    input  logic [CH*N-1:0] data_in,
    output logic [CH-1:0]   ack,
    output logic [CH-1:0]   grant,
    output logic            busy,
    output logic [N-1:0]    sync_word,
    output logic [CW-1:0]   sync_chan,
    output logic            sync_toggle
);

    localparam int HW = $clog2(HOLD);

    state_t        r_state;
    logic [CW-1:0] r_ptr;
    logic [HW-1:0] r_cnt;
    logic [CH-1:0] r_ack;
    logic [CH-1:0] r_grant;
    logic [N-1:0]  r_word;
    logic [CW-1:0] r_chan;
    logic          r_tog;

    logic [CH-1:0] w_elig;
    logic [CW-1:0] w_win;
    logic          w_valid;
    logic [N-1:0]  w_words [CH];

    for (genvar i = 0; i < CH; i++) begin : g_words
        assign w_words[i] = data_in[i*N +: N];
    end

    // A channel whose ack is on this cycle must not win again immediately
    assign w_elig = req & ~r_ack;

    rr_arbiter #(.CH(CH), .CW(CW)) u_arb (
        .eligible  (w_elig),
        .ptr       (r_ptr),
        .win_idx   (w_win),
        .win_valid (w_valid)
    );

    // Grant, hold the word for HOLD cycles, then pulse ack and return to idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= CW'(CH - 1);
            r_cnt   <= '0;
            r_ack   <= '0;
            r_grant <= '0;
            r_word  <= '0;
            r_chan  <= '0;
            r_tog   <= 1'b0;
        end else begin
            r_ack <= '0;
            if (r_state == S_IDLE) begin
                if (w_valid) begin
                    r_word  <= w_words[w_win];
                    r_chan  <= w_win;
                    r_tog   <= ~r_tog;
                    r_grant <= CH'(onehot(int'(w_win), CH));
                    r_ptr   <= w_win;
                    r_cnt   <= HW'(HOLD - 1);
                    r_state <= S_HOLD;
                end
            end else if (r_cnt == '0) begin
                r_ack   <= r_grant;
                r_grant <= '0;
                r_state <= S_IDLE;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign ack         = r_ack;
    assign grant       = r_grant;
    assign busy        = (r_state == S_HOLD);
    assign sync_word   = r_word;
    assign sync_chan   = r_chan;
    assign sync_toggle = r_tog;

endmodule

// File: doc/sync_channel_scheduler.md
# sync_channel_scheduler

Fast-domain scheduler that time-shares one fast-to-slow synchronizer path between several capture channels. Requesters (e.g. ADC channel front ends) post a data word. The block grants them round-robin, loads the granted word plus its channel tag and a toggle flag into a stable output register, and holds it long enough for the slow (VGA) domain to sample it safely. It then acknowledges the requester. The output register feeds the synchronizer input directly; the slow side detects new words by the toggle.

## Interface
Parameters:
- N, 12, data word width
- CH, 4, number of requesting channels (2..16)
- HOLD, 8, fast-clock cycles each word is held stable (must be ≥4 and ≥ two slow-clock periods in fast cycles)
- CW, derived = max(1, $clog2(CH)), channel tag width (localparam)

Ports:
- clk  in  1  fast-domain clock; only clock of the block
- reset  in  1  asynchronous, active-high reset
- req  in  CH  level request per channel; held high until matching ack
- data_in  in  CH*N  channel words, channel i at bits [i*N +: N]
- ack  out  CH  one-cycle pulse, bit i when channel i's hold window completes
- grant  out  CH  one-hot, channel currently being held; 0 when idle
- busy  out  1  high while in S_HOLD
- sync_word  out  N  held data word (to synchronizer)
- sync_chan  out  CW  channel tag of sync_word (to synchronizer)
- sync_toggle  out  1  inverts on every new word (to synchronizer)

## Operation
- States: S_IDLE, S_HOLD.
- S_IDLE: eligible = req & ~ack. If eligible ≠ 0, at the edge:
  - pick the winner w round-robin, searching from ptr+1 upward and wrapping;
  - latch sync_word ← data_in[w], sync_chan ← w, invert sync_toggle;
  - set grant ← onehot(w), ptr ← w, cnt ← HOLD-1;
  - go to S_HOLD.
  - If eligible = 0, stay and hold all outputs.
- S_HOLD: at each edge, if cnt = 0 the block pulses ack[w], clears grant and returns to S_IDLE. Otherwise cnt ← cnt-1.
- req and data_in are sampled only on the grant edge. data_in changes during S_HOLD do not affect sync_word.
- If req[w] drops during S_HOLD, the transfer still completes and ack[w] still pulses.
- ack masking: a channel is ineligible in the cycle its ack is high. A requester that keeps req high for one cycle after ack is not re-granted. A requester holding req continuously is re-served only after the other pending channels.
- sync_word, sync_chan and sync_toggle change only on grant edges. Between grants they hold their last value, including in S_IDLE.
- Reset values: state S_IDLE, ptr = CH-1 (channel 0 has first priority), cnt = 0, ack = 0, grant = 0, busy = 0, sync_word = 0, sync_chan = 0, sync_toggle = 0.
- Reset during S_HOLD aborts the transfer with no ack. The requester re-arbitrates after reset.

## Timing
- Grant edge k: outputs update after edge k, busy = 1.
- Word stable for exactly HOLD cycles of S_HOLD (edges k+1 .. k+HOLD).
- ack registered, high for the cycle after edge k+HOLD; busy = 0 in that same cycle.
- Earliest next grant edge: k+HOLD+1. Word period minimum HOLD+1 cycles.
- Single uncontended request seen at edge k: ack at edge k+HOLD, req-to-ack HOLD+1 cycles.
- All CH channels requesting continuously: each is served once per CH*(HOLD+1) cycles, in order ptr+1, ptr+2, ….

## Structure
- Package sync_sched_pkg: state_t enum {S_IDLE, S_HOLD}, and function onehot(idx, CH).
- Sub-module rr_arbiter: combinational round-robin picker.
  - Inputs: eligible[CH], ptr[CW].
  - Outputs: win_idx[CW], win_valid.
  - Instantiated once.
- Counter, FSM and output registers live in sync_channel_scheduler.

## Test plan
- CH=4, N=12, HOLD=8 throughout.
- Reset check: assert reset with req=4'b1111 -> all outputs 0, no ack. After release, first grant is channel 0 with sync_chan=0, sync_toggle=1.
- Single request: req=4'b0100, data_in[2]=12'hABC at edge k -> sync_word=12'hABC, grant=4'b0100 stable edges k+1..k+8; ack=4'b0100 one cycle after edge k+8; busy low then.
- Full contention: req=4'b1111 held -> grants in order 0,1,2,3,0 at 9-cycle intervals; sync_toggle alternates each grant.
- Late release: channel 1 keeps req high one cycle into its ack cycle, others idle -> no re-grant. If req is still high afterwards, re-grant occurs at the next edge.
- Data change mid-hold: data_in[3] 12'h111 -> 12'h222 two cycles after grant -> sync_word stays 12'h111 until the next grant.
- Abort: assert reset at cnt=3 during channel 2 hold -> ack never pulses for channel 2, outputs cleared. After release with req=4'b0100, channel 2 is re-granted with sync_toggle=1.
